adder_pipe: RTL and testbench

Parametrised, pipelined add/subtract unit with valid/ready flow control. It is the general-width replacement for the fixed 32-bit combinational adder used in the OCR datapath, including the accumulate and normalise paths of the OneByN stage. The carry chain is split into `STAGES` registered chunks so wide operands meet timing. It adds a subtract mode, a signed-overflow flag, optional signed saturation and back-pressure.

---
 rtl/adder_pipe.sv | 128 ++++++++++++
 tb/tb_adder_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract with a chunked carry chain,
// signed overflow flag, optional saturation and valid/ready flow control.
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  logic             w_adv;
  logic [WIDTH-1:0] w_a   [STAGES];
  logic [WIDTH-1:0] w_b   [STAGES];
  logic [WIDTH-1:0] w_s   [STAGES];
  logic             w_cy  [STAGES];
  logic             w_sat [STAGES];
  logic             w_v   [STAGES];

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  assign w_a[0]   = a;
  assign w_b[0]   = sub ? ~b : b;
  assign w_s[0]   = '0;
  assign w_cy[0]  = sub;
  assign w_sat[0] = sat;
  assign w_v[0]   = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW:0]      w_add;
    logic [WIDTH-1:0] w_sum;

    assign w_add = {1'b0, w_a[k][k*CW +: CW]}
                 + {1'b0, w_b[k][k*CW +: CW]}
                 + {{CW{1'b0}}, w_cy[k]};

    always_comb begin
      w_sum = w_s[k];
      w_sum[k*CW +: CW] = w_add[CW-1:0];
    end

    if (k < STAGES - 1) begin : g_mid
      // full operands ride along; upper chunks feed later stages
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_s;
      logic             r_cy;
      logic             r_sat;
      logic             r_v;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a   <= '0;
          r_b   <= '0;
          r_s   <= '0;
          r_cy  <= 1'b0;
          r_sat <= 1'b0;
          r_v   <= 1'b0;
        end else if (w_adv) begin
          r_a   <= w_a[k];
          r_b   <= w_b[k];
          r_s   <= w_sum;
          r_cy  <= w_add[CW];
          r_sat <= w_sat[k];
          r_v   <= w_v[k];
        end
      end

      assign w_a[k+1]   = r_a;
      assign w_b[k+1]   = r_b;
      assign w_s[k+1]   = r_s;
      assign w_cy[k+1]  = r_cy;
      assign w_sat[k+1] = r_sat;
      assign w_v[k+1]   = r_v;
    end else begin : g_last
      logic             w_sgn;
      logic             w_ovf;
      logic [WIDTH-1:0] w_res;
      logic [WIDTH-1:0] r_s;
      logic             r_cy;
      logic             r_ovf;
      logic             r_v;

      assign w_sgn = w_a[k][WIDTH-1];
      assign w_ovf = (w_sgn == w_b[k][WIDTH-1])
                  && (w_sum[WIDTH-1] != w_sgn);

      always_comb begin
        w_res = w_sum;
        if (w_sat[k] && w_ovf)
          w_res = {w_sgn, {(WIDTH-1){~w_sgn}}};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s   <= '0;
          r_cy  <= 1'b0;
          r_ovf <= 1'b0;
          r_v   <= 1'b0;
        end else if (w_adv) begin
          r_s   <= w_res;
          r_cy  <= w_add[CW];
          r_ovf <= w_ovf;
          r_v   <= w_v[k];
        end
      end

      assign s         = r_s;
      assign c         = r_cy;
      assign ovf       = r_ovf;
      assign out_valid = r_v;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: randomized and directed checks of adder_pipe
// against an integer-arithmetic reference model.
module tb_adder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  logic        m_iv, m_ir, m_sub, m_sat, m_ordy, m_ov, m_c, m_f;
  logic [31:0] m_a, m_b, m_s;

  adder_pipe #(.WIDTH(32), .STAGES(4)) u_main (
    .clk(clk), .rst(rst),
    .in_valid(m_iv), .in_ready(m_ir),
    .a(m_a), .b(m_b), .sub(m_sub), .sat(m_sat),
    .out_valid(m_ov), .out_ready(m_ordy),
    .s(m_s), .c(m_c), .ovf(m_f)
  );

  logic [2:0]  sw_iv, sw_sub, sw_sat, sw_ordy;
  logic [2:0]  sw_ir, sw_ov, sw_c, sw_f;
  logic [63:0] sw_a [3];
  logic [63:0] sw_b [3];
  logic [63:0] sw_s [3];
  logic        ir8, ov8, c8, f8;
  logic        ir16, ov16, c16, f16;
  logic        ir64, ov64, c64, f64;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [63:0] s64;

  adder_pipe #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk(clk), .rst(rst),
    .in_valid(sw_iv[0]), .in_ready(ir8),
    .a(sw_a[0][7:0]), .b(sw_b[0][7:0]),
    .sub(sw_sub[0]), .sat(sw_sat[0]),
    .out_valid(ov8), .out_ready(sw_ordy[0]),
    .s(s8), .c(c8), .ovf(f8)
  );

  adder_pipe #(.WIDTH(16), .STAGES(2)) u_w16 (
    .clk(clk), .rst(rst),
    .in_valid(sw_iv[1]), .in_ready(ir16),
    .a(sw_a[1][15:0]), .b(sw_b[1][15:0]),
    .sub(sw_sub[1]), .sat(sw_sat[1]),
    .out_valid(ov16), .out_ready(sw_ordy[1]),
    .s(s16), .c(c16), .ovf(f16)
  );

  adder_pipe #(.WIDTH(64), .STAGES(8)) u_w64 (
    .clk(clk), .rst(rst),
    .in_valid(sw_iv[2]), .in_ready(ir64),
    .a(sw_a[2]), .b(sw_b[2]),
    .sub(sw_sub[2]), .sat(sw_sat[2]),
    .out_valid(ov64), .out_ready(sw_ordy[2]),
    .s(s64), .c(c64), .ovf(f64)
  );

  always_comb begin
    sw_ir   = {ir64, ir16, ir8};
    sw_ov   = {ov64, ov16, ov8};
    sw_c    = {c64, c16, c8};
    sw_f    = {f64, f16, f8};
    sw_s[0] = {56'd0, s8};
    sw_s[1] = {48'd0, s16};
    sw_s[2] = s64;
  end

  // Returns {ovf, c, s}: exact signed/unsigned arithmetic, then wrap/clamp.
  function automatic logic [65:0] model(input int w,
      input logic [63:0] a, input logic [63:0] b,
      input logic sb, input logic st);
    logic [63:0]         mask;
    logic [127:0]        ua, ub, usum;
    logic signed [127:0] sa, sbv, sr, mx, mn, res;
    logic                cy, of;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ua   = {64'd0, a & mask};
    ub   = {64'd0, b & mask};
    sa   = $signed(ua << (128 - w)) >>> (128 - w);
    sbv  = $signed(ub << (128 - w)) >>> (128 - w);
    usum = ua + ub;
    cy   = sb ? (ua >= ub) : usum[w];
    sr   = sb ? sa - sbv : sa + sbv;
    mx   = $signed((128'd1 << (w - 1)) - 128'd1);
    mn   = -mx - 128'sd1;
    of   = (sr > mx) || (sr < mn);
    res  = sr;
    if (st && of) res = (sr > mx) ? mx : mn;
    return {of, cy, 64'(res) & mask};
  endfunction

  task automatic test_reset();
    #2;
    n_tot++;
    if ({m_ov, m_s, m_c, m_f} !== 35'd0) begin
      $display("FAIL reset_out: got ov=%b s=%h c=%b f=%b want 0",
               m_ov, m_s, m_c, m_f);
    end else n_pass++;
    n_tot++;
    if (m_ir !== 1'b1) $display("FAIL reset_ready: got %b want 1", m_ir);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_tot++;
    if ({m_ir, m_ov} !== 2'b10) begin
      $display("FAIL post_reset: got ir=%b ov=%b want 1 0", m_ir, m_ov);
    end else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic [31:0] es [6];
    logic [5:0]  tsub, tsat, ec, ef;
    int          lat;
    ta   = '{32'hFFFF_FFFF, 32'd5, 32'd7,
             32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    tb   = '{32'd1, 32'd7, 32'd5, 32'd1, 32'd1, 32'd1};
    es   = '{32'h0000_0000, 32'hFFFF_FFFE, 32'd2,
             32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    tsub = 6'b100110;
    tsat = 6'b110000;
    ec   = 6'b100101;
    ef   = 6'b111000;
    m_ordy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m_iv  = 1'b1;
      m_a   = ta[i];
      m_b   = tb[i];
      m_sub = tsub[i];
      m_sat = tsat[i];
      @(posedge clk); #1;
      m_iv = 1'b0;
      lat  = 0;
      while (!m_ov && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      n_tot++;
      if (lat != 3) $display("FAIL dir%0d_latency: got %0d want 3", i, lat);
      else n_pass++;
      n_tot++;
      if (m_s !== es[i]) $display("FAIL dir%0d_s: got %h want %h", i, m_s, es[i]);
      else n_pass++;
      n_tot++;
      if (m_c !== ec[i]) $display("FAIL dir%0d_c: got %b want %b", i, m_c, ec[i]);
      else n_pass++;
      n_tot++;
      if (m_f !== ef[i]) $display("FAIL dir%0d_ovf: got %b want %b", i, m_f, ef[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [65:0] q[$];
    logic [65:0] e;
    logic [31:0] hs;
    logic        hc, hf, held, exp_ir;
    int          sent, got, cy;
    sent = 0; got = 0; cy = 0; held = 1'b0;
    hs = '0; hc = 1'b0; hf = 1'b0;
    while (got < 10 && cy < 60) begin
      m_iv   = (sent < 10);
      m_a    = $urandom;
      m_b    = $urandom;
      m_sub  = 1'($urandom_range(0, 1));
      m_sat  = 1'($urandom_range(0, 1));
      m_ordy = !(cy >= 5 && cy <= 7);
      exp_ir = !(cy >= 5 && cy <= 7);
      @(negedge clk);
      if (held) begin
        n_tot++;
        if ({m_ov, m_s, m_c, m_f} !== {1'b1, hs, hc, hf}) begin
          $display("FAIL b2b_hold cy%0d: got ov=%b s=%h want ov=1 s=%h",
                   cy, m_ov, m_s, hs);
        end else n_pass++;
      end
      n_tot++;
      if (m_ir !== exp_ir) begin
        $display("FAIL b2b_ready cy%0d: got %b want %b", cy, m_ir, exp_ir);
      end else n_pass++;
      if (m_ov && m_ordy) begin
        n_tot++;
        if (q.size() == 0) begin
          $display("FAIL b2b_spurious cy%0d: got s=%h want none", cy, m_s);
        end else begin
          e = q.pop_front();
          if ({m_f, m_c, m_s} !== {e[65], e[64], e[31:0]}) begin
            $display("FAIL b2b_result%0d: got %b %b %h want %b %b %h",
                     got, m_f, m_c, m_s, e[65], e[64], e[31:0]);
          end else n_pass++;
        end
        got++;
      end
      if (m_iv && m_ir) begin
        q.push_back(model(32, {32'd0, m_a}, {32'd0, m_b}, m_sub, m_sat));
        sent++;
      end
      held = m_ov && !m_ordy;
      hs = m_s; hc = m_c; hf = m_f;
      @(posedge clk); #1;
      cy++;
    end
    m_iv = 1'b0;
    m_ordy = 1'b1;
    n_tot++;
    if (got != 10) $display("FAIL b2b_count: got %0d want 10", got);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic [65:0] e;
    int          lat;
    m_ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_iv  = 1'b1;
      m_a   = $urandom | 32'h1;
      m_b   = $urandom;
      m_sub = 1'b0;
      m_sat = 1'b0;
      @(posedge clk); #1;
    end
    m_iv = 1'b0;
    @(posedge clk); #1;
    n_tot++;
    if (m_ov !== 1'b1) $display("FAIL rst_inflight: got ov=%b want 1", m_ov);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_tot++;
    if ({m_ov, m_s, m_c, m_f} !== 35'd0) begin
      $display("FAIL rst_async: got ov=%b s=%h c=%b f=%b want 0",
               m_ov, m_s, m_c, m_f);
    end else n_pass++;
    n_tot++;
    if (m_ir !== 1'b1) $display("FAIL rst_ready: got %b want 1", m_ir);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_tot++;
      if (m_ov !== 1'b0) $display("FAIL rst_stale%0d: got ov=%b want 0", i, m_ov);
      else n_pass++;
    end
    m_iv  = 1'b1;
    m_a   = $urandom;
    m_b   = $urandom;
    m_sub = 1'b1;
    m_sat = 1'b1;
    e = model(32, {32'd0, m_a}, {32'd0, m_b}, 1'b1, 1'b1);
    @(posedge clk); #1;
    m_iv = 1'b0;
    lat  = 0;
    while (!m_ov && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tot++;
    if (lat != 3) $display("FAIL rst_next_latency: got %0d want 3", lat);
    else n_pass++;
    n_tot++;
    if ({m_f, m_c, m_s} !== {e[65], e[64], e[31:0]}) begin
      $display("FAIL rst_next_result: got %b %b %h want %b %b %h",
               m_f, m_c, m_s, e[65], e[64], e[31:0]);
    end else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    logic [65:0] ring [3][16];
    logic [65:0] e, act;
    int          hd [3];
    int          tl [3];
    int          sent [3];
    int          got [3];
    int          wid [3];
    int          cy;
    wid = '{8, 16, 64};
    for (int i = 0; i < 3; i++) begin
      hd[i] = 0; tl[i] = 0; sent[i] = 0; got[i] = 0;
    end
    cy = 0;
    while ((got[0] < 1000 || got[1] < 1000 || got[2] < 1000)
           && cy < 20000) begin
      for (int i = 0; i < 3; i++) begin
        sw_iv[i]   = (sent[i] < 1000) && ($urandom_range(0, 3) != 0);
        sw_a[i]    = {$urandom, $urandom};
        sw_b[i]    = {$urandom, $urandom};
        sw_sub[i]  = 1'($urandom_range(0, 1));
        sw_sat[i]  = 1'($urandom_range(0, 1));
        sw_ordy[i] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (sw_ov[i] && sw_ordy[i]) begin
          n_tot++;
          act = {sw_f[i], sw_c[i], sw_s[i]};
          if (hd[i] == tl[i]) begin
            $display("FAIL sweep_w%0d_spurious: got %h want none", wid[i], act);
          end else begin
            e = ring[i][hd[i] % 16];
            hd[i]++;
            if (act !== e) begin
              $display("FAIL sweep_w%0d_result%0d: got %h want %h",
                       wid[i], got[i], act, e);
            end else n_pass++;
          end
          got[i]++;
        end
        if (sw_iv[i] && sw_ir[i]) begin
          ring[i][tl[i] % 16] = model(wid[i], sw_a[i], sw_b[i],
                                      sw_sub[i], sw_sat[i]);
          tl[i]++;
          sent[i]++;
        end
      end
      @(posedge clk); #1;
      cy++;
    end
    sw_iv = '0;
    for (int i = 0; i < 3; i++) begin
      n_tot++;
      if (got[i] != 1000) begin
        $display("FAIL sweep_w%0d_count: got %0d want 1000", wid[i], got[i]);
      end else n_pass++;
    end
  endtask

  initial begin
    m_iv = 1'b0; m_a = '0; m_b = '0;
    m_sub = 1'b0; m_sat = 1'b0; m_ordy = 1'b1;
    sw_iv = '0; sw_sub = '0; sw_sat = '0; sw_ordy = '1;
    for (int i = 0; i < 3; i++) begin
      sw_a[i] = '0;
      sw_b[i] = '0;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
